// File: rtl/ls_station_pkg.sv
// ls_station_pkg: shared tags, widths, funct3 codes, FSM states and bundles
// Helpers: operand snoop, address forcing, misalign test, store lanes.
package ls_station_pkg;

  localparam int WORD_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int REGTAG_W  = 3;

  localparam logic [REGTAG_W-1:0] UNLOCKED   = 3'd0;
  localparam logic [REGTAG_W-1:0] ALU_MASTER = 3'd1;
  localparam logic [REGTAG_W-1:0] ALU_SALVER = 3'd2;
  localparam logic [REGTAG_W-1:0] LOAD_STORE = 3'd3;
  localparam logic [REGTAG_W-1:0] ALU_MISAKA = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_REQ, S_WB
  } ls_state_e;

  typedef struct packed {
    logic                 st;
    logic [2:0]           f3;
    word_t                off;
    logic [REGADDR_W-1:0] aw;
  } ls_op_t;

  typedef struct packed {
    logic [REGTAG_W-1:0] tag;
    word_t               data;
  } opnd_t;

  function automatic opnd_t snoop(
    opnd_t o,
    logic e0, word_t d0,
    logic e1, word_t d1,
    logic e3, word_t d3
  );
    if (o.tag == ALU_MASTER && e0)
      return '{tag: UNLOCKED, data: d0};
    if (o.tag == ALU_SALVER && e1)
      return '{tag: UNLOCKED, data: d1};
    if (o.tag == ALU_MISAKA && e3)
      return '{tag: UNLOCKED, data: d3};
    return o;
  endfunction

  // f3[1] marks word, f3[0] marks half
  function automatic word_t force_align(
    word_t a, logic [2:0] f3
  );
    if (f3[1]) return {a[31:2], 2'b00};
    if (f3[0]) return {a[31:1], 1'b0};
    return a;
  endfunction

  function automatic logic misaligned(
    logic [1:0] a, logic [2:0] f3
  );
    if (f3[1]) return |a;
    if (f3[0]) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] store_be(
    logic [1:0] a, logic [2:0] f3
  );
    if (f3[1]) return 4'b1111;
    if (f3[0]) return 4'b0011 << a;
    return 4'b0001 << a;
  endfunction

  function automatic word_t store_data(
    word_t y, logic [2:0] f3
  );
    if (f3[1]) return y;
    if (f3[0]) return {2{y[15:0]}};
    return {4{y[7:0]}};
  endfunction

endpackage

// File: rtl/ls_station_if.sv
// ls_station_if: memory request bus between load/store station and memory
// master drives req/we/addr/wdata/be; slave returns ready and rdata.
interface ls_station_if;
  import ls_station_pkg::*;

  logic       mem_req_out;
  logic       mem_we_out;
  word_t      mem_addr_out;
  word_t      mem_wdata_out;
  logic [3:0] mem_be_out;
  logic       mem_ready_in;
  word_t      mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out,
    output mem_wdata_out, mem_be_out,
    input  mem_ready_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out,
    input  mem_wdata_out, mem_be_out,
    output mem_ready_in, mem_rdata_in
  );
endinterface

// File: rtl/ls_extend.sv
// ls_extend: picks the loaded lane from a read word and sign/zero-extends it
// Ports: rdata (word), lane (addr[1:0]), f3 (funct3) -> word.
module ls_extend
  import ls_station_pkg::*;
(
  input  word_t      rdata,
  input  logic [1:0] lane,
  input  logic [2:0] f3,
  output word_t      word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (lane)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign h = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    word = rdata;
    unique case (1'b1)
      (f3[1:0] == 2'b00): word = {{24{~f3[2] & b[7]}}, b};
      (f3[1:0] == 2'b01): word = {{16{~f3[2] & h[15]}}, h};
      default:            word = rdata;
    endcase
  end

endmodule

// File: rtl/ls_station.sv
// ls_station: load/store reservation station; waits on tags, issues one memory
// request, writes loads back on bus 2. Ports: issue, snoop buses 0/1/3, mem, wb bus 2.
// LS_ALIGN_CHECK_EN adds ls_misalign_out and traps misaligned H/HU/W.
module ls_station
  import ls_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ls_en_in,
  input  logic [3:0]           ls_op_in,
  input  word_t                ls_offset_in,
  input  logic [REGTAG_W-1:0]  ls_tagx_in,
  input  logic [REGTAG_W-1:0]  ls_tagy_in,
  input  word_t                ls_datax_in,
  input  word_t                ls_datay_in,
  input  logic [REGADDR_W-1:0] ls_addrw_in,
  input  logic                 en_mw0,
  input  word_t                write_data0,
  input  logic                 en_mw1,
  input  word_t                write_data1,
  input  logic                 en_mw3,
  input  word_t                write_data3,
  output logic                 ls_busy_out,
`ifdef LS_ALIGN_CHECK_EN
  output logic                 ls_misalign_out,
`endif
  ls_station_if.master         mem,
  output logic                 en_mw2,
  output logic [REGADDR_W-1:0] reg_write_addr2,
  output word_t                write_data2
);

  ls_state_e  state_q, state_d;
  ls_op_t     op_q;
  opnd_t      x_q, y_q, x_n, y_n;
  word_t      addr_q, wd_q, ld_q, ext;
  logic [3:0] be_q;
  logic       busy_q;
  logic       idle, req, wb, enter_req, mis_d;
  logic       cst;
  logic [2:0] cf3;
  word_t      coff, cx, cy, ea;

  assign x_n = snoop(x_q, en_mw0, write_data0,
                     en_mw1, write_data1, en_mw3, write_data3);
  assign y_n = snoop(y_q, en_mw0, write_data0,
                     en_mw1, write_data1, en_mw3, write_data3);

  // Operands come straight from the issue port on accept,
  // otherwise from the (post-snoop) latched copy.
  assign idle = state_q == S_IDLE;
  assign cst  = idle ? ls_op_in[3]   : op_q.st;
  assign cf3  = idle ? ls_op_in[2:0] : op_q.f3;
  assign coff = idle ? ls_offset_in  : op_q.off;
  assign cx   = idle ? ls_datax_in   : x_n.data;
  assign cy   = idle ? ls_datay_in   : y_n.data;

`ifdef LS_ALIGN_CHECK_EN
  assign ea = cx + coff;
`else
  assign ea = force_align(cx + coff, cf3);
`endif

  always_comb begin
    state_d = state_q;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE:
        if (ls_en_in)
          state_d = (ls_tagx_in == UNLOCKED &&
                     ls_tagy_in == UNLOCKED) ? S_REQ : S_WAIT;
      S_WAIT:
        if (x_n.tag == UNLOCKED && y_n.tag == UNLOCKED)
          state_d = S_REQ;
      S_REQ:
        if (mem.mem_ready_in)
          state_d = op_q.st ? S_IDLE : S_WB;
      S_WB:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    enter_req = state_d == S_REQ && state_q != S_REQ;
`ifdef LS_ALIGN_CHECK_EN
    if (enter_req && misaligned(ea[1:0], cf3)) begin
      state_d   = S_IDLE;
      mis_d     = 1'b1;
      enter_req = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != S_IDLE;
      if (idle && ls_en_in) begin
        op_q <= '{st: ls_op_in[3], f3: ls_op_in[2:0],
                  off: ls_offset_in, aw: ls_addrw_in};
        x_q  <= '{tag: ls_tagx_in, data: ls_datax_in};
        y_q  <= '{tag: ls_tagy_in, data: ls_datay_in};
      end else if (state_q == S_WAIT) begin
        x_q <= x_n;
        y_q <= y_n;
      end
      if (enter_req) begin
        addr_q <= ea;
        be_q   <= cst ? store_be(ea[1:0], cf3) : 4'b1111;
        wd_q   <= store_data(cy, cf3);
      end
      if (state_q == S_REQ && mem.mem_ready_in && !op_q.st)
        ld_q <= ext;
    end
  end

`ifdef LS_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign ls_misalign_out = mis_q;
`endif

  ls_extend u_ext (
    .rdata (mem.mem_rdata_in),
    .lane  (addr_q[1:0]),
    .f3    (op_q.f3),
    .word  (ext)
  );

  // Request/write-back fields are zero outside their states so a
  // reset (which forces IDLE) clears every output at once.
  assign req = state_q == S_REQ;
  assign wb  = state_q == S_WB;

  assign ls_busy_out       = busy_q;
  assign mem.mem_req_out   = req;
  assign mem.mem_we_out    = req & op_q.st;
  assign mem.mem_addr_out  = req ? addr_q : '0;
  assign mem.mem_be_out    = req ? be_q : '0;
  assign mem.mem_wdata_out = (req & op_q.st) ? wd_q : '0;

  assign en_mw2          = wb & (|op_q.aw);
  assign reg_write_addr2 = wb ? op_q.aw : '0;
  assign write_data2     = wb ? ld_q : '0;

endmodule

// File: tb/tb_ls_station.sv
// tb_ls_station: directed bench for ls_station with a transaction-level model
// and a per-cycle compare of memory requests and load write-backs.
module tb_ls_station;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ls_en_in = 1'b0;
  logic [3:0]  ls_op_in = '0;
  logic [31:0] ls_offset_in = '0;
  logic [2:0]  ls_tagx_in = '0, ls_tagy_in = '0;
  logic [31:0] ls_datax_in = '0, ls_datay_in = '0;
  logic [4:0]  ls_addrw_in = '0;
  logic        en_mw0 = 1'b0, en_mw1 = 1'b0, en_mw3 = 1'b0;
  logic [31:0] write_data0 = '0, write_data1 = '0, write_data3 = '0;
  logic        ls_busy_out;
  logic        en_mw2;
  logic [4:0]  reg_write_addr2;
  logic [31:0] write_data2;
`ifdef LS_ALIGN_CHECK_EN
  logic        ls_misalign_out;
`endif

  ls_station_if mif();

  ls_station dut (
    .clk             (clk),
    .rst             (rst),
    .ls_en_in        (ls_en_in),
    .ls_op_in        (ls_op_in),
    .ls_offset_in    (ls_offset_in),
    .ls_tagx_in      (ls_tagx_in),
    .ls_tagy_in      (ls_tagy_in),
    .ls_datax_in     (ls_datax_in),
    .ls_datay_in     (ls_datay_in),
    .ls_addrw_in     (ls_addrw_in),
    .en_mw0          (en_mw0),
    .write_data0     (write_data0),
    .en_mw1          (en_mw1),
    .write_data1     (write_data1),
    .en_mw3          (en_mw3),
    .write_data3     (write_data3),
    .ls_busy_out     (ls_busy_out),
`ifdef LS_ALIGN_CHECK_EN
    .ls_misalign_out (ls_misalign_out),
`endif
    .mem             (mif),
    .en_mw2          (en_mw2),
    .reg_write_addr2 (reg_write_addr2),
    .write_data2     (write_data2)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int req_cnt = 0;
  int wb_cnt  = 0;
  int rcnt    = 0;
  int resp_delay = 0;
  logic [31:0] cur_rdata = '0;

  logic        exp_req_on = 1'b0;
  logic        exp_we = 1'b0;
  logic        exp_mis = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_wb_on = 1'b0;
  logic [4:0]  exp_wb_aw = '0;
  logic [31:0] exp_wb_data = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Transaction model: what one op must put on the bus and write back.
  task automatic model(input logic st, input logic [2:0] f3,
                       input logic [31:0] x, y, off,
                       input logic [4:0] aw,
                       input logic [31:0] rdata);
    int unsigned size;
    int unsigned sh;
    logic [31:0] ea, mask, v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ea = x + off;
    exp_mis = 1'b0;
`ifdef LS_ALIGN_CHECK_EN
    if (ea % size != 0) exp_mis = 1'b1;
`else
    ea = ea - (ea % size);
`endif
    exp_req_on = !exp_mis;
    exp_we   = st;
    exp_addr = ea;
    exp_be   = st ? 4'(((1 << size) - 1) << (ea % 4)) : 4'hF;
    exp_wd   = (size == 1) ? y[7:0] * 32'h0101_0101 :
               (size == 2) ? y[15:0] * 32'h0001_0001 : y;
    sh   = 8 * (ea % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
    v    = (rdata >> sh) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    exp_wb_on   = !st && aw != 0 && !exp_mis;
    exp_wb_aw   = aw;
    exp_wb_data = v;
    cur_rdata   = rdata;
  endtask

  // Compare every cycle, then play memory.
  always @(negedge clk) begin
    if (rst) begin
      if (mif.mem_req_out) begin
        req_cnt++;
        chk("req_expected", 32'd1, {31'd0, exp_req_on});
        chk("req_addr", mif.mem_addr_out, exp_addr);
        chk("req_we", {31'd0, mif.mem_we_out}, {31'd0, exp_we});
        chk("req_be", {28'd0, mif.mem_be_out}, {28'd0, exp_be});
        if (exp_we) chk("req_wdata", mif.mem_wdata_out, exp_wd);
      end
      if (en_mw2) begin
        wb_cnt++;
        chk("wb_expected", 32'd1, {31'd0, exp_wb_on});
        chk("wb_addr", {27'd0, reg_write_addr2}, {27'd0, exp_wb_aw});
        chk("wb_data", write_data2, exp_wb_data);
      end
    end
    if (mif.mem_req_out && rcnt == resp_delay) begin
      mif.mem_ready_in = 1'b1;
      mif.mem_rdata_in = cur_rdata;
    end else begin
      mif.mem_ready_in = 1'b0;
      mif.mem_rdata_in = 32'hBAD0_BAD0;
    end
    rcnt = mif.mem_req_out ? rcnt + 1 : 0;
  end

  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] x, y, off,
                       input logic [2:0] tx, ty,
                       input logic [4:0] aw);
    @(posedge clk); #1;
    ls_en_in = 1'b1;
    ls_op_in = {st, f3};
    ls_datax_in = x;
    ls_datay_in = y;
    ls_offset_in = off;
    ls_tagx_in = tx;
    ls_tagy_in = ty;
    ls_addrw_in = aw;
    @(posedge clk); #1;
    ls_en_in = 1'b0;
    ls_datax_in = 32'h5A5A_5A5A;
    ls_datay_in = 32'hA5A5_A5A5;
    ls_offset_in = 32'h0000_0F00;
    ls_tagx_in = 3'd0;
    ls_tagy_in = 3'd0;
    ls_addrw_in = 5'd31;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!ls_busy_out) done = 1'b1;
    end
    if (!done) chk("idle_timeout", {31'd0, ls_busy_out}, 32'd0);
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3,
                       input logic [31:0] x, y, off,
                       input logic [4:0] aw,
                       input logic [31:0] rdata,
                       input int d);
    int r0, w0;
    model(st, f3, x, y, off, aw, rdata);
    resp_delay = d;
    r0 = req_cnt;
    w0 = wb_cnt;
    issue(st, f3, x, y, off, 3'd0, 3'd0, aw);
    wait_idle();
    chk("req_cycles", req_cnt - r0, exp_req_on ? d + 1 : 0);
    chk("wb_count", wb_cnt - w0, exp_wb_on ? 1 : 0);
  endtask

  task automatic load_lit(input string name, input logic [2:0] f3,
                          input logic [31:0] x,
                          input logic [31:0] rdata,
                          input logic [31:0] lit);
    model(1'b0, f3, x, 32'd0, 32'd0, 5'd6, rdata);
    resp_delay = 0;
    issue(1'b0, f3, x, 32'd0, 32'd0, 3'd0, 3'd0, 5'd6);
    @(negedge clk);
    @(negedge clk);
    chk(name, write_data2, lit);
    wait_idle();
  endtask

  initial begin
    int r0, w0;
    mif.mem_ready_in = 1'b0;
    mif.mem_rdata_in = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, ls_busy_out}, 32'd0);
    chk("rst_req", {31'd0, mif.mem_req_out}, 32'd0);
    chk("rst_en_mw2", {31'd0, en_mw2}, 32'd0);
    chk("rst_addr", mif.mem_addr_out, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // LW earliest timing
    model(1'b0, 3'b010, 32'h100, 32'd0, 32'd4, 5'd5, 32'hDEAD_BEEF);
    resp_delay = 0;
    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'd4, 3'd0, 3'd0, 5'd5);
    @(negedge clk);
    chk("lw_req_c1", {31'd0, mif.mem_req_out}, 32'd1);
    chk("lw_addr", mif.mem_addr_out, 32'h104);
    chk("lw_busy_c1", {31'd0, ls_busy_out}, 32'd1);
    @(negedge clk);
    chk("lw_en_mw2_c2", {31'd0, en_mw2}, 32'd1);
    chk("lw_data", write_data2, 32'hDEAD_BEEF);
    chk("lw_rd", {27'd0, reg_write_addr2}, 32'd5);
    @(negedge clk);
    chk("lw_busy_c3", {31'd0, ls_busy_out}, 32'd0);
    chk("lw_en_mw2_c3", {31'd0, en_mw2}, 32'd0);

    // Load lane extraction
    load_lit("lb_sign", 3'b000, 32'h103, 32'h8012_3456, 32'hFFFF_FF80);
    load_lit("lbu_zero", 3'b100, 32'h103, 32'h8012_3456, 32'h0000_0080);
    load_lit("lhu_hi", 3'b101, 32'h102, 32'hABCD_1234, 32'h0000_ABCD);
    load_lit("lh_sign", 3'b001, 32'h100, 32'h0000_8001, 32'hFFFF_8001);

    // SH lanes
    model(1'b1, 3'b001, 32'h202, 32'h1234, 32'd0, 5'd9, 32'd0);
    resp_delay = 0;
    w0 = wb_cnt;
    issue(1'b1, 3'b001, 32'h202, 32'h1234, 32'd0, 3'd0, 3'd0, 5'd9);
    @(negedge clk);
    chk("sh_be", {28'd0, mif.mem_be_out}, 32'b1100);
    chk("sh_wdata", mif.mem_wdata_out, 32'h1234_1234);
    chk("sh_we", {31'd0, mif.mem_we_out}, 32'd1);
    wait_idle();
    chk("sh_no_wb", wb_cnt - w0, 32'd0);

    // Model-checked variety
    do_op(1'b1, 3'b000, 32'h401, 32'hAB, 32'd0, 5'd1, 32'd0, 0);
    do_op(1'b1, 3'b010, 32'h500, 32'h1357_9BDF, 32'h10, 5'd0, 32'd0, 2);
    do_op(1'b0, 3'b010, 32'h800, 32'd0, 32'h10, 5'd3, 32'h0102_0304, 5);
    do_op(1'b0, 3'b010, 32'h900, 32'd0, 32'd0, 5'd0, 32'h7777_7777, 0);
    do_op(1'b0, 3'b000, 32'hFFFF_FFFE, 32'd0, 32'd3, 5'd12,
          32'h00FF_0000, 1);

    // Operand x waits on ALU_SALVER
    model(1'b0, 3'b010, 32'h40, 32'd0, 32'd8, 5'd4, 32'h1122_3344);
    resp_delay = 0;
    w0 = wb_cnt;
    issue(1'b0, 3'b010, 32'hDEAD_0000, 32'd0, 32'd8, 3'd2, 3'd0, 5'd4);
    en_mw0 = 1'b1;
    write_data0 = 32'h999;
    @(posedge clk); #1;
    en_mw0 = 1'b0;
    @(posedge clk); #1;
    en_mw1 = 1'b1;
    write_data1 = 32'h40;
    @(negedge clk);
    chk("snp_no_req_c3", {31'd0, mif.mem_req_out}, 32'd0);
    chk("snp_busy_c3", {31'd0, ls_busy_out}, 32'd1);
    @(posedge clk); #1;
    en_mw1 = 1'b0;
    @(negedge clk);
    chk("snp_req_c4", {31'd0, mif.mem_req_out}, 32'd1);
    chk("snp_addr", mif.mem_addr_out, 32'h48);
    wait_idle();
    chk("snp_wb", wb_cnt - w0, 32'd1);

    // Store data waits on ALU_MISAKA
    model(1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'hFFFF_FFFC,
          5'd0, 32'd0);
    resp_delay = 0;
    r0 = req_cnt;
    issue(1'b1, 3'b010, 32'h400, 32'd0, 32'hFFFF_FFFC, 3'd0, 3'd4, 5'd0);
    en_mw3 = 1'b1;
    write_data3 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    en_mw3 = 1'b0;
    wait_idle();
    chk("sny_req_cycles", req_cnt - r0, 32'd1);

    // Misaligned word
`ifdef LS_ALIGN_CHECK_EN
    model(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 5'd8, 32'd0);
    r0 = req_cnt;
    w0 = wb_cnt;
    issue(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 3'd0, 3'd0, 5'd8);
    @(negedge clk);
    chk("mis_pulse", {31'd0, ls_misalign_out}, 32'd1);
    @(negedge clk);
    chk("mis_one_cycle", {31'd0, ls_misalign_out}, 32'd0);
    repeat (2) @(negedge clk);
    chk("mis_no_req", req_cnt - r0, 32'd0);
    chk("mis_no_wb", wb_cnt - w0, 32'd0);
`else
    model(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 5'd8, 32'h2468_ACE0);
    resp_delay = 0;
    issue(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 3'd0, 3'd0, 5'd8);
    @(negedge clk);
    chk("lw_forced_addr", mif.mem_addr_out, 32'h100);
    wait_idle();
`endif

    // Reset mid-request
    model(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd7, 32'h55);
    resp_delay = 20;
    w0 = wb_cnt;
    issue(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 3'd0, 3'd0, 5'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, ls_busy_out}, 32'd0);
    chk("arst_req", {31'd0, mif.mem_req_out}, 32'd0);
    chk("arst_addr", mif.mem_addr_out, 32'd0);
    chk("arst_be", {28'd0, mif.mem_be_out}, 32'd0);
    chk("arst_we", {31'd0, mif.mem_we_out}, 32'd0);
    chk("arst_en_mw2", {31'd0, en_mw2}, 32'd0);
    chk("arst_wd2", write_data2, 32'd0);
    exp_req_on = 1'b0;
    exp_wb_on = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    resp_delay = 0;
    repeat (4) @(negedge clk);
    chk("arst_no_wb", wb_cnt - w0, 32'd0);
    chk("arst_idle", {31'd0, ls_busy_out}, 32'd0);

    // Recovery
    do_op(1'b0, 3'b010, 32'h600, 32'd0, 32'h8, 5'd2, 32'h0BAD_F00D, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
